// File: rtl/tt_um_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor tile: FSM states and
// the TinyTapeout pin positions used by the operands, strobe and results.
package tt_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Operand fields on ui_in
    localparam int A_LSB      = 0;
    localparam int B_LSB      = 4;

    // Start strobe on uio_in
    localparam int START_BIT  = 0;

    // Result and flag fields on uo_out
    localparam int DIFF_LSB   = 0;
    localparam int BORROW_BIT = 4;
    localparam int BUSY_BIT   = 5;
    localparam int DONE_BIT   = 6;
    localparam int ZERO_BIT   = 7;

endpackage

// File: rtl/tt_um_serial_subtractor_if.sv
// Bundle of the TinyTapeout tile pins (everything except clk/rst_n).
// The host side drives the enable, operands and strobe; the tile side
// drives the result pins.
interface tt_serial_if;
    import tt_serial_pkg::*;

    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );

endinterface

// File: rtl/tt_um_serial_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module serial_sub_cell
    import tt_serial_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    // Difference bit and borrow generation for a single bit position
    always_comb begin
        d_o    = a_i ^ b_i ^ bin_i;
        bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
    end

endmodule

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial subtractor tile. A rising edge on the start strobe latches
// A and B, the difference is then produced LSB first through a single
// full-subtractor cell, and the result plus borrow/zero flags are shown
// once the last bit is in. Results are masked until done so no partial
// value ever reaches the pins.
module tt_um_serial_subtractor
    import tt_serial_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    // Counter is one bit wider than strictly needed so WIDTH=1 still works
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   aShift_q, aShift_d;
    logic [WIDTH-1:0]   bShift_q, bShift_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               start_q,  start_d;

    logic               startRise;
    logic               cellD;
    logic               cellBout;
    logic               unusedPins;

    assign startRise = uio_in[START_BIT] & ~start_q;

    serial_sub_cell u_cell (
        .a_i    (aShift_q[0]),
        .b_i    (bShift_q[0]),
        .bin_i  (borrow_q),
        .d_o    (cellD),
        .bout_o (cellBout)
    );

    // State register; a low enable freezes everything, including the strobe history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            aShift_q <= '0;
            bShift_q <= '0;
            result_q <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            start_q  <= 1'b0;
        end else if (ena) begin
            state_q  <= state_d;
            aShift_q <= aShift_d;
            bShift_q <= bShift_d;
            result_q <= result_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
        end
    end

    // Next-state logic: load on a start edge when not busy, shift one bit per clock in SHIFT
    always_comb begin
        state_d  = state_q;
        aShift_d = aShift_q;
        bShift_d = bShift_q;
        result_d = result_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        start_d  = uio_in[START_BIT];

        case (state_q)
            IDLE, DONE: begin
                if (startRise) begin
                    aShift_d = ui_in[A_LSB +: WIDTH];
                    bShift_d = ui_in[B_LSB +: WIDTH];
                    result_d = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                aShift_d = aShift_q >> 1;
                bShift_d = bShift_q >> 1;
                result_d = (result_q >> 1) | (WIDTH'(cellD) << (WIDTH - 1));
                borrow_d = cellBout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output mapping: busy during SHIFT, result and flags only while DONE
    always_comb begin
        uo_out           = 8'h00;
        uo_out[BUSY_BIT] = (state_q == SHIFT);
        if (state_q == DONE) begin
            uo_out[DIFF_LSB +: WIDTH] = result_q;
            uo_out[BORROW_BIT]        = borrow_q;
            uo_out[DONE_BIT]          = 1'b1;
            uo_out[ZERO_BIT]          = (result_q == '0);
        end
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    // Upper operand bits (narrow WIDTH) and spare uio pins are not used
    assign unusedPins = &{1'b0, uio_in[7:1], ui_in};

endmodule
